// File: rtl/wb_stage_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, icodes, register IDs,
// the W pipeline-register payload and the writeback FSM state type.
package wb_stage_pkg;

  localparam int unsigned STAT_W  = 4;
  localparam int unsigned ICODE_W = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned WORD_W  = 64;

  // Status codes
  localparam logic [STAT_W-1:0] SBUB = 4'd0;
  localparam logic [STAT_W-1:0] SAOK = 4'd1;
  localparam logic [STAT_W-1:0] SHLT = 4'd2;
  localparam logic [STAT_W-1:0] SADR = 4'd3;
  localparam logic [STAT_W-1:0] SINS = 4'd4;

  // Instruction codes
  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  // Register IDs
  localparam logic [REG_W-1:0] RRAX  = 4'h0;
  localparam logic [REG_W-1:0] RRCX  = 4'h1;
  localparam logic [REG_W-1:0] RRDX  = 4'h2;
  localparam logic [REG_W-1:0] RRBX  = 4'h3;
  localparam logic [REG_W-1:0] RRSP  = 4'h4;
  localparam logic [REG_W-1:0] RNONE = 4'hF;

  // W pipeline register payload
  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [WORD_W-1:0]  val_e;
    logic [WORD_W-1:0]  val_m;
    logic [REG_W-1:0]   dst_e;
    logic [REG_W-1:0]   dst_m;
  } w_reg_t;

  localparam int unsigned W_REG_W = $bits(w_reg_t);

  localparam w_reg_t W_BUBBLE = '{
    stat:  SBUB,
    icode: INOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_t;

  // HLT, ADR, INS and every undefined code (5..15) stop the processor
  function automatic logic stat_stops(input logic [STAT_W-1:0] s);
    return s >= SHLT;
  endfunction

endpackage

// File: rtl/wb_stage_w_pipe_reg.sv
// Generic pipeline register with async reset, stall (hold) and bubble load.
// Ports: clk, rst (async active-high), stall, bubble, d (next value), q.
// Stall has priority over bubble; the bubble value equals the reset value.
module w_pipe_reg #(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= RST_VAL;
    else if (stall)  q <= q;
    else if (bubble) q <= RST_VAL;
    else             q <= d;
  end

endmodule

// File: rtl/wb_stage.sv
// Y86-64 writeback stage: W pipeline register, gated register-file write
// ports, architectural status, sticky halt FSM and retired-instruction count.
// Ports: clk, rst (async active-high); M_* / m_valM_i from memory stage;
// W_stall_i, W_bubble_i pipeline control; W_* register-file write side and
// registered stat/icode; Stat_o, halted_o, retired_o (saturating counter).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STAT_W-1:0]  M_stat_i,
  input  logic [ICODE_W-1:0] M_icode_i,
  input  logic [WORD_W-1:0]  M_valE_i,
  input  logic [WORD_W-1:0]  m_valM_i,
  input  logic [REG_W-1:0]   M_dstE_i,
  input  logic [REG_W-1:0]   M_dstM_i,
  input  logic               W_stall_i,
  input  logic               W_bubble_i,
  output logic [STAT_W-1:0]  W_stat_o,
  output logic [ICODE_W-1:0] W_icode_o,
  output logic [REG_W-1:0]   W_dstE_o,
  output logic [WORD_W-1:0]  W_valE_o,
  output logic [REG_W-1:0]   W_dstM_o,
  output logic [WORD_W-1:0]  W_valM_o,
  output logic [STAT_W-1:0]  Stat_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   retired_o
);

  w_reg_t      w_d;
  w_reg_t      w_q;
  wb_state_t   state;
  wb_state_t   state_nxt;
  logic        w_hold;
  logic        w_ok;
  logic [CNT_W-1:0] retired;

  assign w_d = '{
    stat:  M_stat_i,
    icode: M_icode_i,
    val_e: M_valE_i,
    val_m: m_valM_i,
    dst_e: M_dstE_i,
    dst_m: M_dstM_i
  };

  // A stopping instruction is held from the moment it reaches W, so the
  // fault code stays visible on Stat_o once the FSM reports halted.
  assign w_hold = W_stall_i || (state == ST_HALTED) || stat_stops(w_q.stat);

  w_pipe_reg #(
    .W       (W_REG_W),
    .RST_VAL (W_BUBBLE)
  ) u_w_reg (
    .clk    (clk),
    .rst    (rst),
    .stall  (w_hold),
    .bubble (W_bubble_i),
    .d      (w_d),
    .q      (w_q)
  );

  assign w_ok = (w_q.stat == SAOK);

  // Register-file write side; non-AOK instructions never write
  assign W_stat_o  = w_q.stat;
  assign W_icode_o = w_q.icode;
  assign W_dstE_o  = w_ok ? w_q.dst_e : RNONE;
  assign W_dstM_o  = w_ok ? w_q.dst_m : RNONE;
  assign W_valE_o  = w_q.val_e;
  assign W_valM_o  = w_q.val_m;

  // Bubbles report as AOK architecturally
  assign Stat_o   = (w_q.stat == SBUB) ? SAOK : w_q.stat;
  assign halted_o = (state == ST_HALTED);

  // Halt FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Halt FSM next state; HALTED is sticky until reset
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (stat_stops(w_q.stat)) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Retired count: an AOK instruction leaving W, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if ((state == ST_RUN) && w_ok && !W_stall_i && (retired != '1)) begin
      retired <= retired + CNT_W'(1);
    end
  end

  assign retired_o = retired;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver pushes hand-computed expected
// W-side outputs per clock; a monitor pops and compares after each posedge.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic               clk;
  logic               rst;
  logic [3:0]         M_stat_i;
  logic [3:0]         M_icode_i;
  logic [63:0]        M_valE_i;
  logic [63:0]        m_valM_i;
  logic [3:0]         M_dstE_i;
  logic [3:0]         M_dstM_i;
  logic               W_stall_i;
  logic               W_bubble_i;
  logic [3:0]         W_stat_o;
  logic [3:0]         W_icode_o;
  logic [3:0]         W_dstE_o;
  logic [63:0]        W_valE_o;
  logic [3:0]         W_dstM_o;
  logic [63:0]        W_valM_o;
  logic [3:0]         Stat_o;
  logic               halted_o;
  logic [CNT_W-1:0]   retired_o;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .M_stat_i   (M_stat_i),
    .M_icode_i  (M_icode_i),
    .M_valE_i   (M_valE_i),
    .m_valM_i   (m_valM_i),
    .M_dstE_i   (M_dstE_i),
    .M_dstM_i   (M_dstM_i),
    .W_stall_i  (W_stall_i),
    .W_bubble_i (W_bubble_i),
    .W_stat_o   (W_stat_o),
    .W_icode_o  (W_icode_o),
    .W_dstE_o   (W_dstE_o),
    .W_valE_o   (W_valE_o),
    .W_dstM_o   (W_dstM_o),
    .W_valM_o   (W_valM_o),
    .Stat_o     (Stat_o),
    .halted_o   (halted_o),
    .retired_o  (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [3:0]       stat;
    logic [3:0]       icode;
    logic [3:0]       dst_e;
    logic [63:0]      val_e;
    logic [3:0]       dst_m;
    logic [63:0]      val_m;
    logic [3:0]       st;
    logic             halted;
    logic [CNT_W-1:0] ret;
  } exp_t;

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
  } m_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Register-file model: M port written after E, so valM wins on a tie
  logic [63:0] rf [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 64'd0;
    end else begin
      if (W_dstE_o != 4'hF) rf[W_dstE_o] <= W_valE_o;
      if (W_dstM_o != 4'hF) rf[W_dstM_o] <= W_valM_o;
    end
  end

  function automatic exp_t mk(input logic [3:0] stat, input logic [3:0] icode,
                              input logic [3:0] dst_e, input logic [63:0] val_e,
                              input logic [3:0] dst_m, input logic [63:0] val_m,
                              input logic [3:0] st, input logic halted, input int ret);
    exp_t e;
    e.name = "";
    e.stat = stat; e.icode = icode; e.dst_e = dst_e; e.val_e = val_e;
    e.dst_m = dst_m; e.val_m = val_m; e.st = st; e.halted = halted;
    e.ret = CNT_W'(ret);
    return e;
  endfunction

  function automatic m_t mm(input logic [3:0] stat, input logic [3:0] icode,
                            input logic [3:0] dst_e, input logic [63:0] val_e,
                            input logic [3:0] dst_m, input logic [63:0] val_m);
    m_t m;
    m.stat = stat; m.icode = icode; m.dst_e = dst_e; m.val_e = val_e;
    m.dst_m = dst_m; m.val_m = val_m;
    return m;
  endfunction

  function automatic exp_t bub_exp(input logic halted, input int ret);
    return mk(4'd0, 4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 4'd1, halted, ret);
  endfunction

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (W_stat_o !== e.stat || W_icode_o !== e.icode || W_dstE_o !== e.dst_e ||
        W_valE_o !== e.val_e || W_dstM_o !== e.dst_m || W_valM_o !== e.val_m ||
        Stat_o !== e.st || halted_o !== e.halted || retired_o !== e.ret) begin
      n_bad++;
      $display("FAIL %s: got stat=%h icode=%h dstE=%h valE=%h dstM=%h valM=%h Stat=%h halted=%b retired=%0d; want stat=%h icode=%h dstE=%h valE=%h dstM=%h valM=%h Stat=%h halted=%b retired=%0d",
               name, W_stat_o, W_icode_o, W_dstE_o, W_valE_o, W_dstM_o, W_valM_o,
               Stat_o, halted_o, retired_o, e.stat, e.icode, e.dst_e, e.val_e,
               e.dst_m, e.val_m, e.st, e.halted, e.ret);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one cycle of M inputs/control and queue the post-edge expectation
  task automatic step(input string name, input m_t m, input logic stall,
                      input logic bubble, input exp_t e);
    @(negedge clk);
    M_stat_i  = m.stat;  M_icode_i = m.icode;
    M_dstE_i  = m.dst_e; M_valE_i  = m.val_e;
    M_dstM_i  = m.dst_m; m_valM_i  = m.val_m;
    W_stall_i = stall;   W_bubble_i = bubble;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare every queued expectation just after its clock edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    m_t bub;
    bub = mm(4'd0, 4'h1, 4'hF, 64'd0, 4'hF, 64'd0);
    rst = 1'b1;
    M_stat_i = bub.stat; M_icode_i = bub.icode; M_dstE_i = bub.dst_e;
    M_valE_i = bub.val_e; M_dstM_i = bub.dst_m; m_valM_i = bub.val_m;
    W_stall_i = 1'b0; W_bubble_i = 1'b0;

    repeat (2) @(negedge clk);
    check("reset", bub_exp(1'b0, 0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step("idle", bub, 1'b0, 1'b0, bub_exp(1'b0, 0));

    // irmovq $0x1234, %rax
    step("irmovq", mm(4'd1, 4'h3, 4'h0, 64'h1234, 4'hF, 64'd0), 1'b0, 1'b0,
         mk(4'd1, 4'h3, 4'h0, 64'h1234, 4'hF, 64'd0, 4'd1, 1'b0, 0));
    step("irmovq_retire", bub, 1'b0, 1'b0, bub_exp(1'b0, 1));
    #2 check_val("rf_rax", rf[0], 64'h1234);

    // popq %rsp: both ports target %rsp
    step("popq_rsp", mm(4'd1, 4'hB, 4'h4, 64'h100, 4'h4, 64'h200), 1'b0, 1'b0,
         mk(4'd1, 4'hB, 4'h4, 64'h100, 4'h4, 64'h200, 4'd1, 1'b0, 1));
    // stall and bubble together: hold, no retire
    step("stall_over_bubble", mm(4'd1, 4'h3, 4'h5, 64'h555, 4'hF, 64'd0), 1'b1, 1'b1,
         mk(4'd1, 4'hB, 4'h4, 64'h100, 4'h4, 64'h200, 4'd1, 1'b0, 1));
    #2 check_val("rf_rsp_valM_wins", rf[4], 64'h200);
    // bubble alone: popq retires, W becomes bubble
    step("bubble_only", mm(4'd1, 4'h3, 4'h5, 64'h555, 4'hF, 64'd0), 1'b0, 1'b1,
         bub_exp(1'b0, 2));

    // mrmovq with address fault
    step("load_fault", mm(4'd3, 4'h5, 4'hF, 64'd0, 4'h3, 64'hDEAD), 1'b0, 1'b0,
         mk(4'd3, 4'h5, 4'hF, 64'd0, 4'hF, 64'hDEAD, 4'd3, 1'b0, 2));
    step("halt_enter", mm(4'd1, 4'h3, 4'h0, 64'h77, 4'hF, 64'd0), 1'b0, 1'b0,
         mk(4'd3, 4'h5, 4'hF, 64'd0, 4'hF, 64'hDEAD, 4'd3, 1'b1, 2));
    step("halt_frozen", mm(4'd1, 4'h3, 4'h1, 64'h88, 4'hF, 64'd0), 1'b0, 1'b1,
         mk(4'd3, 4'h5, 4'hF, 64'd0, 4'hF, 64'hDEAD, 4'd3, 1'b1, 2));
    #2 check_val("rf_rbx_no_fault_write", rf[3], 64'd0);
    check_val("rf_rax_untouched", rf[0], 64'h1234);

    // async reset while halted, checked before any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_halted", bub_exp(1'b0, 0));
    @(negedge clk);
    rst = 1'b0;

    // undefined status 7 behaves as a stopping fault and is gated
    step("stat7", mm(4'd7, 4'h6, 4'h2, 64'h5, 4'hF, 64'd0), 1'b0, 1'b0,
         mk(4'd7, 4'h6, 4'hF, 64'h5, 4'hF, 64'd0, 4'd7, 1'b0, 0));
    step("stat7_halt", bub, 1'b0, 1'b0,
         mk(4'd7, 4'h6, 4'hF, 64'h5, 4'hF, 64'd0, 4'd7, 1'b1, 0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // counter saturation at 15 with CNT_W = 4
    for (int k = 1; k <= 20; k++) begin
      step("saturate", mm(4'd1, 4'h3, 4'h0, 64'(k), 4'hF, 64'd0), 1'b0, 1'b0,
           mk(4'd1, 4'h3, 4'h0, 64'(k), 4'hF, 64'd0, 4'd1, 1'b0, (k - 1 > 15) ? 15 : k - 1));
    end
    step("saturate_hold", bub, 1'b0, 1'b0, bub_exp(1'b0, 15));

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
